vend_dispenser: RTL and testbench

//  Dispense-side responder for a confirmed purchase. Accepts a vend request (line/column) from the

---
 rtl/vend_pkg.sv | 28 ++
 rtl/vend_sync_edge.sv | 30 +++
 rtl/vend_dispenser.sv | 167 ++++++++++++++++
 tb/tb_vend_dispenser.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vend types and constants for the dispenser, controller and admin blocks.
// Slot geometry and fail codes live here so every block agrees on them.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPIN,
    ST_WAIT_DROP,
    ST_REPORT
  } vend_state_e;

  localparam logic [1:0] VEND_OK       = 2'b00;
  localparam logic [1:0] VEND_BAD_ADDR = 2'b01;
  localparam logic [1:0] VEND_NO_DROP  = 2'b10;
  localparam logic [1:0] VEND_STUCK    = 2'b11;

  localparam logic [2:0] NUM_LINES   = 3'd6;
  localparam logic [3:0] NUM_COLUMNS = 4'd8;

  function automatic logic [5:0] line_onehot(input logic [2:0] l);
    line_onehot = 6'b1 << (l - 3'd1);
  endfunction

  function automatic logic [7:0] col_onehot(input logic [3:0] c);
    col_onehot = 8'b1 << (c - 4'd1);
  endfunction

endpackage

// File: rtl/vend_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, plus a rising-edge pulse.
// level is the synchronised value; rise is high for one cycle per 0->1.
module vend_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/vend_dispenser.sv
// Dispense-side responder: spins the addressed slot motor, watches the drop sensor.
// Optional macro VEND_DISPENSE_COUNT_EN adds a saturating dispense_count output.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned MOTOR_ON_CYCLES     = 25_000_000,
  parameter int unsigned DROP_TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned RETRY_MAX           = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vend_req,
  input  logic [2:0]  vend_line,
  input  logic [3:0]  vend_column,
  input  logic        drop_sensor,
  output logic        vend_ack,
  output logic        vend_busy,
  output logic        vend_done,
  output logic        vend_fail,
  output logic [1:0]  fail_code,
  output logic [5:0]  motor_line_sel,
  output logic [7:0]  motor_col_sel,
`ifdef VEND_DISPENSE_COUNT_EN
  output logic [15:0] dispense_count,
`endif
  output logic        motor_en
);

  localparam int unsigned CNT_MAX =
    (MOTOR_ON_CYCLES > DROP_TIMEOUT_CYCLES) ?
    MOTOR_ON_CYCLES : DROP_TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int RW =
    (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [CW-1:0] MOTOR_LAST =
    CW'(MOTOR_ON_CYCLES - 1);
  localparam logic [CW-1:0] DROP_LAST =
    CW'(DROP_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

  vend_state_e    state;
  logic [CW-1:0]  cnt;
  logic [RW-1:0]  retries;
  logic [2:0]     line_q;
  logic [3:0]     col_q;
  logic [1:0]     code_q;
  logic           drop_level;
  logic           drop_rise;
  logic           bad_addr;

  vend_sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (drop_sensor),
    .level    (drop_level),
    .rise     (drop_rise)
  );

  assign bad_addr = (vend_line == 3'd0)
                  | (vend_line > NUM_LINES)
                  | (vend_column == 4'd0)
                  | (vend_column > NUM_COLUMNS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      retries        <= '0;
      line_q         <= '0;
      col_q          <= '0;
      code_q         <= VEND_OK;
      vend_ack       <= 1'b0;
      vend_busy      <= 1'b0;
      vend_done      <= 1'b0;
      vend_fail      <= 1'b0;
      fail_code      <= VEND_OK;
      motor_en       <= 1'b0;
      motor_line_sel <= '0;
      motor_col_sel  <= '0;
`ifdef VEND_DISPENSE_COUNT_EN
      dispense_count <= '0;
`endif
    end else begin
      vend_ack  <= 1'b0;
      vend_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (vend_req) begin
            line_q    <= vend_line;
            col_q     <= vend_column;
            vend_ack  <= 1'b1;
            vend_busy <= 1'b1;
            vend_fail <= 1'b0;
            fail_code <= VEND_OK;
            retries   <= '0;
            cnt       <= '0;
            // Address check deliberately precedes the stuck-sensor check.
            if (bad_addr) begin
              code_q <= VEND_BAD_ADDR;
              state  <= ST_REPORT;
            end else if (drop_level) begin
              code_q <= VEND_STUCK;
              state  <= ST_REPORT;
            end else begin
              motor_en       <= 1'b1;
              motor_line_sel <= line_onehot(vend_line);
              motor_col_sel  <= col_onehot(vend_column);
              state          <= ST_SPIN;
            end
          end
        end
        ST_SPIN: begin
          if (drop_rise) begin
            motor_en       <= 1'b0;
            motor_line_sel <= '0;
            motor_col_sel  <= '0;
            code_q         <= VEND_OK;
            state          <= ST_REPORT;
          end else if (cnt == MOTOR_LAST) begin
            motor_en       <= 1'b0;
            motor_line_sel <= '0;
            motor_col_sel  <= '0;
            cnt            <= '0;
            state          <= ST_WAIT_DROP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_DROP: begin
          if (drop_rise) begin
            code_q <= VEND_OK;
            state  <= ST_REPORT;
          end else if (cnt == DROP_LAST) begin
            cnt <= '0;
            if (retries < RETRY_LIM) begin
              retries        <= retries + 1'b1;
              motor_en       <= 1'b1;
              motor_line_sel <= line_onehot(line_q);
              motor_col_sel  <= col_onehot(col_q);
              state          <= ST_SPIN;
            end else begin
              code_q <= VEND_NO_DROP;
              state  <= ST_REPORT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_REPORT: begin
          vend_done <= 1'b1;
          vend_fail <= (code_q != VEND_OK);
          fail_code <= code_q;
          vend_busy <= 1'b0;
          retries   <= '0;
          state     <= ST_IDLE;
`ifdef VEND_DISPENSE_COUNT_EN
          if (code_q == VEND_OK && dispense_count != 16'hFFFF)
            dispense_count <= dispense_count + 16'd1;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_dispenser.sv
// Scoreboard bench for vend_dispenser with short motor/timeout parameters.
// Expected done results are queued per request and checked on vend_done.
module tb_vend_dispenser;
  import vend_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vend_req = 1'b0;
  logic [2:0]  vend_line = '0;
  logic [3:0]  vend_column = '0;
  logic        drop_sensor = 1'b0;
  logic        vend_ack;
  logic        vend_busy;
  logic        vend_done;
  logic        vend_fail;
  logic [1:0]  fail_code;
  logic [5:0]  motor_line_sel;
  logic [7:0]  motor_col_sel;
  logic        motor_en;
`ifdef VEND_DISPENSE_COUNT_EN
  logic [15:0] dispense_count;
`endif

  vend_dispenser #(
    .MOTOR_ON_CYCLES     (4),
    .DROP_TIMEOUT_CYCLES (6),
    .RETRY_MAX           (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .vend_req       (vend_req),
    .vend_line      (vend_line),
    .vend_column    (vend_column),
    .drop_sensor    (drop_sensor),
    .vend_ack       (vend_ack),
    .vend_busy      (vend_busy),
    .vend_done      (vend_done),
    .vend_fail      (vend_fail),
    .fail_code      (fail_code),
    .motor_line_sel (motor_line_sel),
    .motor_col_sel  (motor_col_sel),
`ifdef VEND_DISPENSE_COUNT_EN
    .dispense_count (dispense_count),
`endif
    .motor_en       (motor_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       fail;
    logic [1:0] code;
  } exp_t;

  exp_t sbq[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int ack_cyc = 0;
  int done_cyc = 0;
  int motor_cyc = 0;
  int exp_disp = 0;
  logic [14:0] sel_at_ack = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (vend_ack) begin
      ack_cnt++;
      ack_cyc = cyc;
      sel_at_ack = {motor_en, motor_line_sel, motor_col_sel};
    end
    if (motor_en) motor_cyc++;
    if (vend_done) begin
      done_cnt++;
      done_cyc = cyc;
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'(vend_done), 0);
      end else begin
        e = sbq.pop_front();
        chk("fail", 32'(vend_fail), 32'(e.fail));
        chk("code", 32'(fail_code), 32'(e.code));
        chk("motor_off_at_done",
            {motor_en, motor_line_sel, motor_col_sel}, 0);
        if (e.code == VEND_OK) exp_disp++;
      end
    end
  end

  task automatic vend(input logic [2:0] l, input logic [3:0] c,
                      input int sens_dly, input logic ef,
                      input logic [1:0] ec, input int exp_lat,
                      input int exp_motor, input logic [14:0] exp_sel);
    int a0, d0, m0, n;
    a0 = ack_cnt;
    d0 = done_cnt;
    m0 = motor_cyc;
    sbq.push_back(exp_t'({ef, ec}));
    @(posedge clk);
    #1;
    vend_line = l;
    vend_column = c;
    vend_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (ack_cnt == a0 && n < 8);
    #1 vend_req = 1'b0;
    chk("ack", ack_cnt - a0, 1);
    chk("sel_at_ack", 32'(sel_at_ack), 32'(exp_sel));
    if (sens_dly >= 0) begin
      repeat (sens_dly) @(posedge clk);
      #1 drop_sensor = 1'b1;
    end
    n = 0;
    while (done_cnt == d0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", done_cnt - d0, 1);
    chk("latency", done_cyc - ack_cyc, exp_lat);
    chk("motor_cycles", motor_cyc - m0, exp_motor);
    #1 drop_sensor = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int a0, d0, n;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {vend_ack, vend_busy, vend_done, vend_fail, fail_code,
         motor_line_sel, motor_col_sel, motor_en}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    vend(3'd2, 4'd3, 0, 1'b0, VEND_OK, 5, 4,
         {1'b1, 6'b000010, 8'b00000100});
    vend(3'd6, 4'd8, 5, 1'b0, VEND_OK, 10, 4,
         {1'b1, 6'b100000, 8'b10000000});
    vend(3'd1, 4'd1, -1, 1'b1, VEND_NO_DROP, 21, 8,
         {1'b1, 6'b000001, 8'b00000001});
    vend(3'd7, 4'd1, -1, 1'b1, VEND_BAD_ADDR, 1, 0, 0);
    vend(3'd3, 4'd0, -1, 1'b1, VEND_BAD_ADDR, 1, 0, 0);
    vend(3'd0, 4'd9, -1, 1'b1, VEND_BAD_ADDR, 1, 0, 0);

    #1 drop_sensor = 1'b1;
    repeat (3) @(posedge clk);
    vend(3'd4, 4'd4, -1, 1'b1, VEND_STUCK, 1, 0, 0);
    #1 drop_sensor = 1'b1;
    repeat (3) @(posedge clk);
    vend(3'd7, 4'd8, -1, 1'b1, VEND_BAD_ADDR, 1, 0, 0);

    a0 = ack_cnt;
    d0 = done_cnt;
    sbq.push_back(exp_t'({1'b1, VEND_BAD_ADDR}));
    sbq.push_back(exp_t'({1'b1, VEND_BAD_ADDR}));
    @(posedge clk);
    #1;
    vend_line = 3'd0;
    vend_column = 4'd3;
    vend_req = 1'b1;
    n = 0;
    while (ack_cnt - a0 < 2 && n < 12) begin
      @(posedge clk);
      n++;
    end
    #1 vend_req = 1'b0;
    repeat (4) @(posedge clk);
    chk("retrigger_acks", ack_cnt - a0, 2);
    chk("retrigger_dones", done_cnt - d0, 2);

    a0 = ack_cnt;
    @(posedge clk);
    #1;
    vend_line = 3'd4;
    vend_column = 4'd5;
    vend_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (ack_cnt == a0 && n < 8);
    #1 vend_req = 1'b0;
    chk("abort_ack", ack_cnt - a0, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    exp_disp = 0;
    d0 = done_cnt;
    #1;
    chk("abort_motor",
        {motor_en, motor_line_sel, motor_col_sel}, 0);
    chk("abort_busy", 32'(vend_busy), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    chk("abort_no_done", done_cnt - d0, 0);

    vend(3'd5, 4'd7, 1, 1'b0, VEND_OK, 6, 4,
         {1'b1, 6'b010000, 8'b01000000});
`ifdef VEND_DISPENSE_COUNT_EN
    vend(3'd1, 4'd8, 0, 1'b0, VEND_OK, 5, 4,
         {1'b1, 6'b000001, 8'b10000000});
    vend(3'd6, 4'd1, 2, 1'b0, VEND_OK, 7, 4,
         {1'b1, 6'b100000, 8'b00000001});
    vend(3'd2, 4'd2, -1, 1'b1, VEND_NO_DROP, 21, 8,
         {1'b1, 6'b000010, 8'b00000010});
    chk("dispense_model", exp_disp, 3);
    chk("dispense_count", 32'(dispense_count), exp_disp);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
